// File: rtl/sp_pkg.sv
// Shared definitions for the bandscope capture scheduler: state encoding and default sizes.
package sp_pkg;

  typedef enum logic [2:0] {
    SP_IDLE  = 3'd0,
    SP_ARM   = 3'd1,
    SP_FILL  = 3'd2,
    SP_DRAIN = 3'd3,
    SP_HOLD  = 3'd4
  } sp_state_t;

  localparam int SP_CAP_LEN_DEF  = 16384;
  localparam int SP_FRAME_CNT_W  = 16;

endpackage

// File: rtl/sp_decim_ctr.sv
// Modulo-(ratio+1) counter of valid samples; hit is high when the count is 0 (sample to keep).
module sp_decim_ctr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic [W-1:0] ratio,
  input  logic         step,
  output logic         hit
);

  logic [W-1:0] ratio_q;
  logic [W-1:0] cnt_q;

  // clear also latches the ratio so it stays fixed for the whole frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ratio_q <= '0;
      cnt_q   <= '0;
    end else if (clear) begin
      ratio_q <= ratio;
      cnt_q   <= '0;
    end else if (step) begin
      cnt_q <= (cnt_q == ratio_q) ? '0 : cnt_q + 1'b1;
    end
  end

  assign hit = (cnt_q == '0);

endmodule

// File: rtl/sp_capture_sched.sv
// Counted, rate-limited capture scheduler for the SP sample FIFO.
// Optional trigger gating of ARM->FILL is built when SP_TRIG_EN is defined.
//
// state | meaning
// IDLE  | waiting for cfg_enable with an empty FIFO
// ARM   | latch decimation, clear counters (waits for trig_in rise with SP_TRIG_EN)
// FILL  | writing decimated samples until CAP_LEN writes or FIFO full
// DRAIN | frame complete, waiting for readout to empty the FIFO
// HOLD  | holdoff down-count before returning to IDLE
module sp_capture_sched
  import sp_pkg::*;
#(
  parameter int CAP_LEN = SP_CAP_LEN_DEF,
  parameter int HOLD_W  = 24,
  parameter int DEC_W   = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cfg_enable,
  input  logic [DEC_W-1:0]          cfg_decim,
  input  logic [HOLD_W-1:0]         cfg_holdoff,
  input  logic                      sample_valid,
  input  logic                      fifo_wrempty,
  input  logic                      fifo_wrfull,
  input  logic                      trig_in,
  output logic                      fifo_write,
  output logic                      have_sp_data,
  output logic [SP_FRAME_CNT_W-1:0] frame_cnt,
  output logic                      ovf_sticky
);

  localparam int CNT_W = $clog2(CAP_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CAP_LEN - 1);

  sp_state_t         state_q, state_d;
  logic [CNT_W-1:0]  samp_q;
  logic [HOLD_W-1:0] hold_q;
  logic              decim_hit;
  logic              decim_clr;
  logic              decim_step;
  logic              empty_eff;
  logic              trig_rise;

  // empty and full together is illegal; full wins
  assign empty_eff = fifo_wrempty & ~fifo_wrfull;

`ifdef SP_TRIG_EN
  logic trig_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) trig_q <= 1'b0;
    else          trig_q <= trig_in;
  end
  assign trig_rise = trig_in & ~trig_q;
`else
  logic unused_trig;
  assign unused_trig = trig_in;
  assign trig_rise   = 1'b1;
`endif

  assign decim_step = (state_q == SP_FILL) & sample_valid;
  assign fifo_write = (state_q == SP_FILL) & sample_valid & decim_hit & ~fifo_wrfull;

  sp_decim_ctr #(.W(DEC_W)) u_decim (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (decim_clr),
    .ratio   (cfg_decim),
    .step    (decim_step),
    .hit     (decim_hit)
  );

  always_comb begin
    state_d   = state_q;
    decim_clr = 1'b0;
    case (state_q)
      SP_IDLE:  if (cfg_enable && empty_eff) state_d = SP_ARM;
      SP_ARM: begin
        decim_clr = 1'b1;
`ifdef SP_TRIG_EN
        if (!cfg_enable)    state_d = SP_IDLE;
        else if (trig_rise) state_d = SP_FILL;
`else
        if (trig_rise)      state_d = SP_FILL;
`endif
      end
      SP_FILL: begin
        if (fifo_wrfull)                          state_d = SP_DRAIN;
        else if (fifo_write && samp_q == LAST_IDX) state_d = SP_DRAIN;
      end
      SP_DRAIN: if (empty_eff)      state_d = SP_HOLD;
      SP_HOLD:  if (hold_q == '0)   state_d = SP_IDLE;
      default:                      state_d = SP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= SP_IDLE;
      samp_q       <= '0;
      hold_q       <= '0;
      have_sp_data <= 1'b0;
      frame_cnt    <= '0;
      ovf_sticky   <= 1'b0;
    end else begin
      state_q      <= state_d;
      have_sp_data <= (state_d == SP_DRAIN);
      if (state_q == SP_ARM)  samp_q <= '0;
      else if (fifo_write)    samp_q <= samp_q + 1'b1;
      if (state_q == SP_DRAIN && state_d == SP_HOLD) begin
        hold_q    <= cfg_holdoff;
        frame_cnt <= frame_cnt + 1'b1;
      end else if (state_q == SP_HOLD && hold_q != '0) begin
        hold_q <= hold_q - 1'b1;
      end
      if (state_q == SP_FILL && fifo_wrfull) ovf_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sp_capture_sched.sv
// Directed testbench for sp_capture_sched with CAP_LEN=16; trigger scenario built when SP_TRIG_EN is defined.
module tb_sp_capture_sched;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cfg_enable;
  logic [3:0]  cfg_decim;
  logic [23:0] cfg_holdoff;
  logic        sample_valid;
  logic        fifo_wrempty;
  logic        fifo_wrfull;
  logic        trig_in;
  logic        fifo_write;
  logic        have_sp_data;
  logic [15:0] frame_cnt;
  logic        ovf_sticky;

  int n_vec = 0;
  int n_err = 0;
  int cyc, wr_cnt, first_wr, last_wr, have_first, have_cnt, full_limit;
  int wr_log[$];

  sp_capture_sched #(.CAP_LEN(16), .HOLD_W(24), .DEC_W(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cfg_enable   (cfg_enable),
    .cfg_decim    (cfg_decim),
    .cfg_holdoff  (cfg_holdoff),
    .sample_valid (sample_valid),
    .fifo_wrempty (fifo_wrempty),
    .fifo_wrfull  (fifo_wrfull),
    .trig_in      (trig_in),
    .fifo_write   (fifo_write),
    .have_sp_data (have_sp_data),
    .frame_cnt    (frame_cnt),
    .ovf_sticky   (ovf_sticky)
  );

  always #5 clk = ~clk;

  task automatic clear_log();
    cyc = 0; wr_cnt = 0; first_wr = -1; last_wr = -1;
    have_first = -1; have_cnt = 0;
    wr_log.delete();
  endtask

  // Called at posedge+1; FIFO model updates inputs there, outputs sampled at the negedge.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      if (full_limit > 0 && wr_cnt >= full_limit) begin
        fifo_wrfull  = 1'b1;
        fifo_wrempty = 1'b0;
      end
      #4;
      if (fifo_write) begin
        if (wr_cnt == 0) first_wr = cyc;
        last_wr = cyc;
        wr_log.push_back(cyc);
        wr_cnt++;
      end
      if (have_sp_data) begin
        if (have_first < 0) have_first = cyc;
        have_cnt++;
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    cfg_enable = 1'b1; sample_valid = 1'b1;
    #2;
    n_vec++; if (fifo_write !== 1'b0)    begin n_err++; $display("FAIL reset_fifo_write got %b want 0", fifo_write); end
    n_vec++; if (have_sp_data !== 1'b0)  begin n_err++; $display("FAIL reset_have got %b want 0", have_sp_data); end
    n_vec++; if (frame_cnt !== 16'd0)    begin n_err++; $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt); end
    n_vec++; if (ovf_sticky !== 1'b0)    begin n_err++; $display("FAIL reset_ovf got %b want 0", ovf_sticky); end
    cfg_enable = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_basic_frame();
    clear_log();
    cfg_decim = 4'd0; cfg_holdoff = 24'd0;
    cfg_enable = 1'b1; run(1);
    cfg_enable = 1'b0; run(30);
    n_vec++; if (wr_cnt !== 16)     begin n_err++; $display("FAIL basic_writes got %0d want 16", wr_cnt); end
    n_vec++; if (first_wr !== 2)    begin n_err++; $display("FAIL basic_first got %0d want 2", first_wr); end
    n_vec++; if (last_wr !== 17)    begin n_err++; $display("FAIL basic_last got %0d want 17", last_wr); end
    n_vec++; if (have_first !== 18) begin n_err++; $display("FAIL basic_have_first got %0d want 18", have_first); end
    n_vec++; if (have_cnt !== 1)    begin n_err++; $display("FAIL basic_have_cycles got %0d want 1", have_cnt); end
    n_vec++; if (frame_cnt !== 16'd1) begin n_err++; $display("FAIL basic_frame_cnt got %0d want 1", frame_cnt); end
  endtask

  task automatic test_decim();
    int bad;
    clear_log();
    cfg_decim = 4'd3;
    cfg_enable = 1'b1; run(1);
    cfg_enable = 1'b0; run(80);
    bad = 0;
    for (int k = 0; k < wr_log.size(); k++) if (wr_log[k] != 2 + 4 * k) bad++;
    n_vec++; if (wr_cnt !== 16)     begin n_err++; $display("FAIL decim_writes got %0d want 16", wr_cnt); end
    n_vec++; if (bad !== 0)         begin n_err++; $display("FAIL decim_spacing got %0d off-grid writes want 0", bad); end
    n_vec++; if (have_first !== 63) begin n_err++; $display("FAIL decim_have_first got %0d want 63", have_first); end
    n_vec++; if (frame_cnt !== 16'd2) begin n_err++; $display("FAIL decim_frame_cnt got %0d want 2", frame_cnt); end
    cfg_decim = 4'd0;
  endtask

  task automatic test_overflow();
    clear_log();
    full_limit = 10;
    cfg_enable = 1'b1; run(1);
    cfg_enable = 1'b0; run(19);
    n_vec++; if (wr_cnt !== 10)       begin n_err++; $display("FAIL ovf_writes got %0d want 10", wr_cnt); end
    n_vec++; if (ovf_sticky !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", ovf_sticky); end
    n_vec++; if (have_first !== 13)   begin n_err++; $display("FAIL ovf_have_first got %0d want 13", have_first); end
    n_vec++; if (have_sp_data !== 1'b1) begin n_err++; $display("FAIL ovf_have_held got %b want 1", have_sp_data); end
    n_vec++; if (frame_cnt !== 16'd2) begin n_err++; $display("FAIL ovf_frame_cnt_pre got %0d want 2", frame_cnt); end
    full_limit = 0; fifo_wrfull = 1'b0; fifo_wrempty = 1'b1;
    run(5);
    n_vec++; if (frame_cnt !== 16'd3) begin n_err++; $display("FAIL ovf_frame_cnt_post got %0d want 3", frame_cnt); end
    n_vec++; if (have_sp_data !== 1'b0) begin n_err++; $display("FAIL ovf_have_clear got %b want 0", have_sp_data); end
  endtask

  task automatic test_holdoff();
    clear_log();
    cfg_holdoff = 24'd100;
    cfg_enable = 1'b1; run(125);
    cfg_enable = 1'b0; run(135);
    n_vec++; if (wr_cnt !== 32) begin n_err++; $display("FAIL hold_writes got %0d want 32", wr_cnt); end
    if (wr_cnt >= 32) begin
      n_vec++; if (wr_log[15] !== 17)  begin n_err++; $display("FAIL hold_frame1_last got %0d want 17", wr_log[15]); end
      n_vec++; if (wr_log[16] !== 122) begin n_err++; $display("FAIL hold_rearm got %0d want 122", wr_log[16]); end
      n_vec++; if (wr_log[31] !== 137) begin n_err++; $display("FAIL hold_frame2_last got %0d want 137", wr_log[31]); end
    end
    n_vec++; if (frame_cnt !== 16'd5) begin n_err++; $display("FAIL hold_frame_cnt got %0d want 5", frame_cnt); end
    cfg_holdoff = 24'd0;
  endtask

  task automatic test_reset_mid_fill();
    clear_log();
    cfg_enable = 1'b1; run(1);
    cfg_enable = 1'b0; run(7);
    n_vec++; if (fifo_write !== 1'b1) begin n_err++; $display("FAIL midrst_pre_write got %b want 1", fifo_write); end
    reset_n = 1'b0;
    #1;
    n_vec++; if (fifo_write !== 1'b0)   begin n_err++; $display("FAIL midrst_write got %b want 0", fifo_write); end
    n_vec++; if (frame_cnt !== 16'd0)   begin n_err++; $display("FAIL midrst_frame_cnt got %0d want 0", frame_cnt); end
    n_vec++; if (ovf_sticky !== 1'b0)   begin n_err++; $display("FAIL midrst_ovf got %b want 0", ovf_sticky); end
    n_vec++; if (have_sp_data !== 1'b0) begin n_err++; $display("FAIL midrst_have got %b want 0", have_sp_data); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    clear_log();
    cfg_enable = 1'b1; run(1);
    cfg_enable = 1'b0; run(30);
    n_vec++; if (wr_cnt !== 16)   begin n_err++; $display("FAIL midrst_restart_writes got %0d want 16", wr_cnt); end
    n_vec++; if (first_wr !== 2)  begin n_err++; $display("FAIL midrst_restart_first got %0d want 2", first_wr); end
    n_vec++; if (frame_cnt !== 16'd1) begin n_err++; $display("FAIL midrst_restart_frame_cnt got %0d want 1", frame_cnt); end
  endtask

  task automatic test_trigger();
    clear_log();
    trig_in = 1'b0;
    cfg_enable = 1'b1; run(20);
    n_vec++; if (wr_cnt !== 0) begin n_err++; $display("FAIL trig_none got %0d writes want 0", wr_cnt); end
    cfg_enable = 1'b0; run(3);
    trig_in = 1'b1; run(3);
    cfg_enable = 1'b1; run(20);
    n_vec++; if (wr_cnt !== 0) begin n_err++; $display("FAIL trig_held got %0d writes want 0", wr_cnt); end
    trig_in = 1'b0; run(2);
    clear_log();
    trig_in = 1'b1; run(1);
    cfg_enable = 1'b0; run(30);
    n_vec++; if (first_wr !== 1) begin n_err++; $display("FAIL trig_first got %0d want 1", first_wr); end
    n_vec++; if (wr_cnt !== 16)  begin n_err++; $display("FAIL trig_writes got %0d want 16", wr_cnt); end
    trig_in = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; cfg_enable = 1'b0; cfg_decim = 4'd0; cfg_holdoff = 24'd0;
    sample_valid = 1'b1; fifo_wrempty = 1'b1; fifo_wrfull = 1'b0; trig_in = 1'b0;
    full_limit = 0;
    clear_log();
    @(posedge clk); @(posedge clk); #1;
    test_reset();
`ifdef SP_TRIG_EN
    test_trigger();
`else
    test_basic_frame();
    test_decim();
    test_overflow();
    test_holdoff();
    test_reset_mid_fill();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
